// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             bo;

  modport master (
    output start, x, y, bi,
    input  busy, done, f, bo
  );

  modport slave (
    input  start, x, y, bi,
    output busy, done, f, bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial two's-complement subtractor f = x - y - bi with borrow-out
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave s
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]       r_xs;
  logic [WIDTH-1:0]       r_ys;
  logic [WIDTH-1:0]       r_res;
  logic [WIDTH-1:0]       r_f;
  logic                   r_borrow;
  logic                   r_bo;
  logic [CW-1:0]          r_count;

  logic [DIGIT:0]         w_digit;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]       w_res_next;
  logic                   w_last;
  logic                   w_capture;

  // Low digit difference; the extra top bit is set exactly when this digit borrows.
  assign w_digit    = {1'b0, r_xs[DIGIT-1:0]} - {1'b0, r_ys[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, r_borrow};
  // New digit enters the result from the MSB end so the LSB digit ends up at bit 0.
  assign w_res_cat  = {w_digit[DIGIT-1:0], r_res};
  assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last     = (r_count == CW'(N - 1));
  // Start is only honoured outside RUN, which also gives back-to-back issue from DONE.
  assign w_capture  = s.start && (r_state != RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: IDLE/DONE accept a start, RUN lasts exactly N edges.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = s.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand shift registers, running borrow, digit counter and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xs     <= '0;
      r_ys     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_f      <= '0;
      r_bo     <= 1'b0;
    end else if (w_capture) begin
      r_xs     <= s.x;
      r_ys     <= s.y;
      r_res    <= '0;
      r_borrow <= s.bi;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_xs     <= r_xs >> DIGIT;
      r_ys     <= r_ys >> DIGIT;
      r_res    <= w_res_next;
      r_borrow <= w_digit[DIGIT];
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_f  <= w_res_next;
        r_bo <= w_digit[DIGIT];
      end
    end
  end

  assign s.busy = (r_state == RUN);
  assign s.done = (r_state == DONE);
  assign s.f    = r_f;
  assign s.bo   = r_bo;

endmodule
